// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package bin_to_bcd_digits_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the
  // shift, so the shift carries it correctly into the next decade. Inputs are
  // always 0..9, so the result never exceeds 12 and fits in four bits.
  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/bin_to_bcd_digits_digit_cell.sv
// One BCD digit slice: add-3 correction followed by a one-bit left shift.
// The bit shifted in comes from the slice below; the bit shifted out goes to
// the slice above. Purely combinational.
module bcd_digit_cell
  import bin_to_bcd_digits_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  input  logic                   carry_in,
  output logic [BCD_DIGIT_W-1:0] digit_out,
  output logic                   carry_out
);

  logic [BCD_DIGIT_W-1:0] adjusted;

  // Correct the digit, then shift it left, pulling in the lower bit.
  always_comb begin
    adjusted  = bcd_add3(digit_in);
    digit_out = {adjusted[BCD_DIGIT_W-2:0], carry_in};
    carry_out = adjusted[BCD_DIGIT_W-1];
  end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
//
// Handshake: a value is transferred on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE (and low during
// reset); the source must hold in_valid and in_value until that edge. There
// is no output backpressure: out_valid is a one-cycle strobe, and
// out_digits/overflow stay stable until the next strobe.
module bin_to_bcd_digits
  import bin_to_bcd_digits_pkg::*;
#(
  parameter int BIN_WIDTH  = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [BIN_WIDTH-1:0]              in_value,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] out_digits,
  output logic                              overflow,
  output logic                              busy
);

  localparam int SCR_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [SCR_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  bcd_state_t           state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [SCR_W-1:0]     scratch_q;
  logic [SCR_W-1:0]     scratch_next;
  logic                 scratch_ovf_q;
  logic                 ovf_next;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_DIGITS:0]  carry;

  // The top bit of the binary shift register feeds digit 0.
  assign carry[0] = shift_q[BIN_WIDTH-1];

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_digit_cell u_cell (
        .digit_in  (scratch_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .carry_in  (carry[k]),
        .digit_out (scratch_next[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .carry_out (carry[k+1])
      );
    end
  endgenerate

  // A bit leaving the top digit means the value does not fit; it is sticky.
  assign ovf_next = scratch_ovf_q | carry[NUM_DIGITS];

  // Handshake and status decode from the current state.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE) && !reset;
  assign busy      = (state_q != IDLE);

  // Control FSM, shift datapath and result registers. The result is captured
  // on the final shift edge so it is already visible during the DONE cycle,
  // alongside the out_valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      scratch_q     <= '0;
      scratch_ovf_q <= 1'b0;
      cnt_q         <= '0;
      out_digits    <= '0;
      overflow      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q       <= in_value;
            scratch_q     <= '0;
            scratch_ovf_q <= 1'b0;
            cnt_q         <= CNT_W'(BIN_WIDTH);
            state_q       <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q       <= shift_q << 1;
          scratch_q     <= scratch_next;
          scratch_ovf_q <= ovf_next;
          cnt_q         <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            overflow   <= ovf_next;
            out_digits <= ovf_next ? ALL_NINES : scratch_next;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed bench for bin_to_bcd_digits: default instance (16 bits, 5 digits)
// plus a 4-digit instance for the saturation case.
module tb_bin_to_bcd_digits;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_value;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] out_digits;
  logic        overflow;
  logic        busy;

  logic        in_valid4;
  logic [15:0] in_value4;
  logic        in_ready4;
  logic        out_valid4;
  logic [15:0] out_digits4;
  logic        overflow4;
  logic        busy4;

  int vectors = 0;
  int miscompares = 0;

  bin_to_bcd_digits #(.BIN_WIDTH(16), .NUM_DIGITS(5)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .overflow   (overflow),
    .busy       (busy)
  );

  bin_to_bcd_digits #(.BIN_WIDTH(16), .NUM_DIGITS(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid4),
    .in_value   (in_value4),
    .in_ready   (in_ready4),
    .out_valid  (out_valid4),
    .out_digits (out_digits4),
    .overflow   (overflow4),
    .busy       (busy4)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // With in_valid already high, wait (bounded) for in_ready, then cross the
  // accepting edge. Returns at the start of cycle 1.
  task automatic wait_accept();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    repeat (3) step();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (out_digits !== 20'h00000) begin miscompares++; $display("FAIL reset_digits: got %h, required 00000", out_digits); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
    step();
  endtask

  task automatic test_single_12345();
    in_value = 16'd12345;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL single_in_ready c=%0d: got %b, required 0", c, in_ready); end
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy c=%0d: got %b, required 1", c, busy); end
      vectors++;
      if (out_valid !== (c == 17)) begin miscompares++; $display("FAIL single_out_valid c=%0d: got %b, required %b", c, out_valid, (c == 17)); end
      if (c == 17) begin
        vectors++;
        if (out_digits !== 20'h12345) begin miscompares++; $display("FAIL single_digits: got %h, required 12345", out_digits); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL single_overflow: got %b, required 0", overflow); end
      end
      step();
    end
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_return_idle: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
    end
    vectors++;
    if (out_digits !== 20'h12345) begin miscompares++; $display("FAIL single_hold: got %h, required 12345", out_digits); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    in_value = 16'd65535;
    in_valid = 1'b1;
    wait_accept();
    in_value = 16'd0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid === 1'b1) pulses++;
      vectors++;
      if (out_valid !== (c == 17 || c == 35)) begin
        miscompares++;
        $display("FAIL b2b_out_valid c=%0d: got %b, required %b", c, out_valid, (c == 17 || c == 35));
      end
      if (c == 17) begin
        vectors++;
        if (out_digits !== 20'h65535 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_first: got %h ovf %b, required 65535 ovf 0", out_digits, overflow);
        end
      end
      if (c == 18) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_first_idle_ready: got %b, required 1", in_ready); end
      end
      if (c == 35) begin
        vectors++;
        if (out_digits !== 20'h00000 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_second: got %h ovf %b, required 00000 ovf 0", out_digits, overflow);
        end
      end
      step();
      if (c == 18) in_valid = 1'b0;
    end
    vectors++;
    if (pulses != 2) begin miscompares++; $display("FAIL b2b_pulse_count: got %0d, required 2", pulses); end
  endtask

  task automatic test_ignore_changes();
    in_value = 16'd255;
    in_valid = 1'b1;
    wait_accept();
    for (int c = 1; c <= 24; c++) begin
      if (c <= 16) begin
        in_value = 16'($urandom_range(0, 65535));
        in_valid = (c % 2 == 1);
      end else begin
        in_valid = 1'b0;
      end
      vectors++;
      if (out_valid !== (c == 17)) begin miscompares++; $display("FAIL ignore_out_valid c=%0d: got %b, required %b", c, out_valid, (c == 17)); end
      if (c == 17) begin
        vectors++;
        if (out_digits !== 20'h00255 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL ignore_digits: got %h ovf %b, required 00255 ovf 0", out_digits, overflow);
        end
      end
      step();
    end
    in_value = '0;
  endtask

  task automatic test_reset_mid();
    in_value = 16'd4321;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_in_ready: got %b, required 1", in_ready); end
    vectors++;
    if (out_digits !== 20'h00000 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h ovf %b, required 00000 ovf 0", out_digits, overflow);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    for (int c = 0; c < 25; c++) begin
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_no_pulse c=%0d: got %b, required 0", c, out_valid); end
      step();
    end
    in_value = 16'd4321;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      vectors++;
      if (out_valid !== (c == 17)) begin miscompares++; $display("FAIL fresh_out_valid c=%0d: got %b, required %b", c, out_valid, (c == 17)); end
      if (c == 17) begin
        vectors++;
        if (out_digits !== 20'h04321 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL fresh_digits: got %h ovf %b, required 04321 ovf 0", out_digits, overflow);
        end
      end
      step();
    end
  endtask

  task automatic test_overflow_4digit();
    logic [15:0] values [2];
    logic        exp_ovf [2];
    int n;
    values[0] = 16'd10000; exp_ovf[0] = 1'b1;
    values[1] = 16'd9999;  exp_ovf[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      in_value4 = values[t];
      in_valid4 = 1'b1;
      n = 0;
      while (in_ready4 !== 1'b1 && n < 50) begin
        step();
        n++;
      end
      vectors++;
      if (in_ready4 !== 1'b1) begin miscompares++; $display("FAIL ov4_accept_timeout: in_ready=%b, required 1", in_ready4); end
      step();
      in_valid4 = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        vectors++;
        if (out_valid4 !== (c == 17)) begin miscompares++; $display("FAIL ov4_out_valid t=%0d c=%0d: got %b, required %b", t, c, out_valid4, (c == 17)); end
        if (c == 17) begin
          vectors++;
          if (out_digits4 !== 16'h9999) begin miscompares++; $display("FAIL ov4_digits t=%0d: got %h, required 9999", t, out_digits4); end
          vectors++;
          if (overflow4 !== exp_ovf[t]) begin miscompares++; $display("FAIL ov4_overflow t=%0d: got %b, required %b", t, overflow4, exp_ovf[t]); end
        end
        step();
      end
    end
  endtask

  // Test sequence and summary
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    in_valid4 = 1'b0;
    in_value4 = '0;
    test_reset();
    test_single_12345();
    test_back_to_back();
    test_ignore_changes();
    test_reset_mid();
    test_overflow_4digit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
